// File: rtl/edge_delta_recovery.sv
// edge_delta_recovery
// Measures the high and low phase widths of a recovered clock from its
// per-cycle rise/fall edge events, counted in enabled system-clock cycles.
// The widths feed the generation-side rate inputs once they are stable.
//
// Ports:
//   clk                 system clock
//   sync_rst_n          synchronous reset, active-low
//   clk_en              clock enable; when low, state holds and edges are lost
//   measure_en_i        enables measurement (low parks the block in IDLE)
//   clear_state_i       soft clear, qualified by clk_en
//   rise_edge_i         recovered rising-edge pulse (closes a low phase)
//   fall_edge_i         recovered falling-edge pulse (closes a high phase)
//   high_delta_o        last measured high-phase width
//   low_delta_o         last measured low-phase width
//   delta_valid_o       pulse when either delta register updates
//   deltas_locked_in_o  widths have matched LOCK_COUNT times in a row
//   timeout_o           pulse when the elapsed counter saturates
//   edge_error_o        pulse on simultaneous rise and fall
module edge_delta_recovery #(
  parameter int RATE_COUNTER_WIDTH = 16,
  parameter int LOCK_COUNT         = 4,
  parameter int TOLERANCE          = 1
) (
  input  logic                          clk,
  input  logic                          sync_rst_n,
  input  logic                          clk_en,
  input  logic                          measure_en_i,
  input  logic                          clear_state_i,
  input  logic                          rise_edge_i,
  input  logic                          fall_edge_i,
  output logic [RATE_COUNTER_WIDTH-1:0] high_delta_o,
  output logic [RATE_COUNTER_WIDTH-1:0] low_delta_o,
  output logic                          delta_valid_o,
  output logic                          deltas_locked_in_o,
  output logic                          timeout_o,
  output logic                          edge_error_o
);

  localparam int W = RATE_COUNTER_WIDTH;
  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX      = {W{1'b1}};
  localparam logic [W-1:0] NEAR_MAX = {{(W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0] TOL      = W'(TOLERANCE);
  localparam logic [3:0]   LOCK_CNT = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, SYNC, TRAIN, LOCKED} state_t;

  state_t       state;
  logic [W-1:0] elapsed;
  logic [3:0]   match_cnt;
  logic         prev_high_valid;
  logic         prev_low_valid;

  logic         single_edge;
  logic         both_edges;
  logic [W-1:0] captured;
  logic [W-1:0] prev_delta;
  logic         prev_valid;
  logic [W-1:0] diff;
  logic         is_match;
  logic [3:0]   match_next;

  // A rise closes a low phase and a fall closes a high phase, so the value
  // compared against is the stored delta of the polarity being captured.
  always_comb begin
    single_edge = rise_edge_i ^ fall_edge_i;
    both_edges  = rise_edge_i & fall_edge_i;
    captured    = elapsed + ONE;
    prev_delta  = rise_edge_i ? low_delta_o : high_delta_o;
    prev_valid  = rise_edge_i ? prev_low_valid : prev_high_valid;
    diff        = (captured >= prev_delta) ? (captured - prev_delta)
                                           : (prev_delta - captured);
    is_match    = (diff <= TOL);
    match_next  = match_cnt;
    if (prev_valid) begin
      if (!is_match)
        match_next = 4'd0;
      else if (match_cnt >= LOCK_CNT)
        match_next = LOCK_CNT;
      else
        match_next = match_cnt + 4'd1;
    end
  end

  // Single state machine with registered outputs. Pulses are cleared by
  // default every enabled cycle and also whenever clk_en is low.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state              <= IDLE;
      elapsed            <= '0;
      match_cnt          <= '0;
      prev_high_valid    <= 1'b0;
      prev_low_valid     <= 1'b0;
      high_delta_o       <= '0;
      low_delta_o        <= '0;
      delta_valid_o      <= 1'b0;
      deltas_locked_in_o <= 1'b0;
      timeout_o          <= 1'b0;
      edge_error_o       <= 1'b0;
    end else if (!clk_en) begin
      delta_valid_o <= 1'b0;
      timeout_o     <= 1'b0;
      edge_error_o  <= 1'b0;
    end else begin
      delta_valid_o <= 1'b0;
      timeout_o     <= 1'b0;
      edge_error_o  <= 1'b0;
      if (clear_state_i) begin
        state              <= measure_en_i ? SYNC : IDLE;
        elapsed            <= '0;
        match_cnt          <= '0;
        prev_high_valid    <= 1'b0;
        prev_low_valid     <= 1'b0;
        high_delta_o       <= '0;
        low_delta_o        <= '0;
        deltas_locked_in_o <= 1'b0;
      end else if (!measure_en_i) begin
        // Deltas hold so downstream keeps its last rate; lock is forgotten.
        state              <= IDLE;
        elapsed            <= '0;
        match_cnt          <= '0;
        prev_high_valid    <= 1'b0;
        prev_low_valid     <= 1'b0;
        deltas_locked_in_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= SYNC;
            elapsed <= '0;
          end
          // The first edge only aligns the counter; a partial phase is
          // never captured.
          SYNC: begin
            if (both_edges) begin
              edge_error_o <= 1'b1;
              elapsed      <= '0;
            end else if (single_edge) begin
              elapsed <= '0;
              state   <= TRAIN;
            end else if (elapsed != MAX) begin
              elapsed <= elapsed + ONE;
            end
          end
          TRAIN, LOCKED: begin
            if (both_edges) begin
              edge_error_o       <= 1'b1;
              elapsed            <= '0;
              state              <= SYNC;
              match_cnt          <= '0;
              prev_high_valid    <= 1'b0;
              prev_low_valid     <= 1'b0;
              deltas_locked_in_o <= 1'b0;
            end else if (single_edge) begin
              elapsed       <= '0;
              delta_valid_o <= 1'b1;
              match_cnt     <= match_next;
              if (rise_edge_i) begin
                low_delta_o    <= captured;
                prev_low_valid <= 1'b1;
              end else begin
                high_delta_o    <= captured;
                prev_high_valid <= 1'b1;
              end
              if (prev_valid && !is_match) begin
                deltas_locked_in_o <= 1'b0;
                state              <= TRAIN;
              end else if (match_next == LOCK_CNT) begin
                deltas_locked_in_o <= 1'b1;
                state              <= LOCKED;
              end
            end else if (elapsed == NEAR_MAX) begin
              // Counter is about to saturate: the input has stopped toggling.
              elapsed            <= MAX;
              timeout_o          <= 1'b1;
              state              <= SYNC;
              match_cnt          <= '0;
              prev_high_valid    <= 1'b0;
              prev_low_valid     <= 1'b0;
              deltas_locked_in_o <= 1'b0;
            end else begin
              elapsed <= elapsed + ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_edge_delta_recovery.sv
// tb_edge_delta_recovery
// Directed bench for edge_delta_recovery with an 8-bit counter so that
// saturation is reachable quickly. Inputs change 1 time unit after each
// rising clock edge and outputs are sampled at the same point.
module tb_edge_delta_recovery;

  logic       clk;
  logic       sync_rst_n;
  logic       clk_en;
  logic       measure_en;
  logic       clear_state;
  logic       rise;
  logic       fall;
  logic [7:0] high_delta;
  logic [7:0] low_delta;
  logic       delta_valid;
  logic       locked;
  logic       timeout;
  logic       edge_error;

  int checks;
  int failures;

  edge_delta_recovery #(
    .RATE_COUNTER_WIDTH(8),
    .LOCK_COUNT(4),
    .TOLERANCE(1)
  ) dut (
    .clk                (clk),
    .sync_rst_n         (sync_rst_n),
    .clk_en             (clk_en),
    .measure_en_i       (measure_en),
    .clear_state_i      (clear_state),
    .rise_edge_i        (rise),
    .fall_edge_i        (fall),
    .high_delta_o       (high_delta),
    .low_delta_o        (low_delta),
    .delta_valid_o      (delta_valid),
    .deltas_locked_in_o (locked),
    .timeout_o          (timeout),
    .edge_error_o       (edge_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present an edge event for exactly one clock; on return the capture
  // triggered by that edge is visible on the outputs.
  task automatic applyStimulus(input logic r, input logic f);
    rise = r;
    fall = f;
    tick();
    rise = 1'b0;
    fall = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    sync_rst_n  = 1'b0;
    clk_en      = 1'b1;
    measure_en  = 1'b0;
    clear_state = 1'b0;
    rise        = 1'b0;
    fall        = 1'b0;
    idle(3);
    checkOutput("rst_high", int'(high_delta), 0);
    checkOutput("rst_low", int'(low_delta), 0);
    checkOutput("rst_valid", int'(delta_valid), 0);
    checkOutput("rst_lock", int'(locked), 0);
    checkOutput("rst_timeout", int'(timeout), 0);
    checkOutput("rst_err", int'(edge_error), 0);

    // Square wave: 5 cycles high, 3 low.
    sync_rst_n = 1'b1;
    measure_en = 1'b1;
    idle(2);
    applyStimulus(1'b1, 1'b0);
    checkOutput("sync_edge_no_valid", int'(delta_valid), 0);
    idle(4);
    applyStimulus(1'b0, 1'b1);
    checkOutput("seed_high", int'(high_delta), 5);
    checkOutput("seed_high_valid", int'(delta_valid), 1);
    tick();
    checkOutput("valid_one_cycle", int'(delta_valid), 0);
    idle(1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("seed_low", int'(low_delta), 3);
    for (int k = 0; k < 2; k++) begin
      idle(4);
      applyStimulus(1'b0, 1'b1);
      checkOutput("train_high", int'(high_delta), 5);
      checkOutput("train_lock_fall", int'(locked), 0);
      idle(2);
      applyStimulus(1'b1, 1'b0);
      checkOutput("train_lock_rise", int'(locked), (k == 1) ? 1 : 0);
    end

    // Jitter within tolerance keeps lock, a large step breaks it.
    idle(5);
    applyStimulus(1'b0, 1'b1);
    checkOutput("jitter_high6", int'(high_delta), 6);
    checkOutput("jitter_lock6", int'(locked), 1);
    idle(2);
    applyStimulus(1'b1, 1'b0);
    idle(4);
    applyStimulus(1'b0, 1'b1);
    checkOutput("jitter_high5", int'(high_delta), 5);
    checkOutput("jitter_lock5", int'(locked), 1);
    idle(2);
    applyStimulus(1'b1, 1'b0);
    idle(8);
    applyStimulus(1'b0, 1'b1);
    checkOutput("step_high9", int'(high_delta), 9);
    checkOutput("step_unlock", int'(locked), 0);
    for (int k = 0; k < 2; k++) begin
      idle(2);
      applyStimulus(1'b1, 1'b0);
      checkOutput("relock_rise", int'(locked), 0);
      idle(8);
      applyStimulus(1'b0, 1'b1);
      checkOutput("relock_fall", int'(locked), (k == 1) ? 1 : 0);
    end

    // Simultaneous edges while locked.
    idle(2);
    applyStimulus(1'b1, 1'b1);
    checkOutput("err_pulse", int'(edge_error), 1);
    checkOutput("err_lock", int'(locked), 0);
    checkOutput("err_high_hold", int'(high_delta), 9);
    checkOutput("err_low_hold", int'(low_delta), 3);
    checkOutput("err_no_valid", int'(delta_valid), 0);
    tick();
    checkOutput("err_one_cycle", int'(edge_error), 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("err_sync_no_capture", int'(delta_valid), 0);
    idle(4);
    applyStimulus(1'b0, 1'b1);
    checkOutput("err_reseed_high", int'(high_delta), 5);
    checkOutput("err_reseed_valid", int'(delta_valid), 1);

    // No edges: counter saturates at 255.
    idle(254);
    checkOutput("pre_timeout", int'(timeout), 0);
    tick();
    checkOutput("timeout_pulse", int'(timeout), 1);
    checkOutput("timeout_lock", int'(locked), 0);
    tick();
    checkOutput("timeout_one_cycle", int'(timeout), 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("timeout_sync_no_valid", int'(delta_valid), 0);
    checkOutput("timeout_high_hold", int'(high_delta), 5);

    // clk_en toggling; enabled on even raw cycles. The rise at raw cycle 5
    // lands on a disabled cycle and must be lost.
    for (int i = 0; i <= 10; i++) begin
      clk_en = (i % 2 == 0);
      rise   = (i == 0) || (i == 5);
      fall   = (i == 10);
      tick();
      if (i == 0) checkOutput("en_low_seed", int'(low_delta), 1);
      if (i == 1) checkOutput("en_pulse_drop", int'(delta_valid), 0);
      if (i == 6) checkOutput("en_lost_edge", int'(delta_valid), 0);
    end
    rise   = 1'b0;
    fall   = 1'b0;
    clk_en = 1'b1;
    checkOutput("en_high5", int'(high_delta), 5);
    checkOutput("en_valid", int'(delta_valid), 1);
    checkOutput("en_low_hold", int'(low_delta), 1);

    // Relock, then a one-cycle reset mid-lock.
    idle(2);
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      idle(4);
      applyStimulus(1'b0, 1'b1);
      idle(2);
      applyStimulus(1'b1, 1'b0);
    end
    checkOutput("relock2", int'(locked), 1);
    sync_rst_n = 1'b0;
    tick();
    sync_rst_n = 1'b1;
    checkOutput("midrst_high", int'(high_delta), 0);
    checkOutput("midrst_low", int'(low_delta), 0);
    checkOutput("midrst_lock", int'(locked), 0);

    // Soft clear with measurement still enabled.
    tick();
    applyStimulus(1'b1, 1'b0);
    idle(4);
    applyStimulus(1'b0, 1'b1);
    checkOutput("preclear_high", int'(high_delta), 5);
    idle(2);
    clear_state = 1'b1;
    tick();
    clear_state = 1'b0;
    checkOutput("clear_high", int'(high_delta), 0);
    checkOutput("clear_low", int'(low_delta), 0);
    checkOutput("clear_lock", int'(locked), 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("clear_sync_no_capture", int'(delta_valid), 0);
    idle(4);
    applyStimulus(1'b0, 1'b1);
    checkOutput("clear_capture", int'(high_delta), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
